im_controller: RTL and testbench
================================

# im_controller

Sequencing FSM for the intelligent-mouse maze datapath. It drives the X/Y position registers, their inc/dec units and the stack-and-queue component to run a depth-first search from cell (0,0) to a goal cell in a 16x16 maze. It marks visited cells in the external maze RAM and, on success, streams the recorded path out through the datapath's tri-stated Move port using a valid/ready handshake. It sits beside the datapath in the mouse top level; the top level wires the maze RAM and the datapath to it.

## Interface
- GOAL_X, default 4'd15, goal column.
- GOAL_Y, default 4'd15, goal row.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  level; sampled in IDLE, DONE and FAIL.
- poseX, poseY  in  4 each  datapath candidate position (register value after the inc/dec requested this cycle).
- overflow  in  1  datapath inc/dec wrap flag, combinational.
- topValueSQ  in  2  stack top direction.
- SQ_Empty, SQ_Done  in  1 each  stack empty; queue fully read.
- mem_rdata  in  1  maze RAM asynchronous read at {poseY,poseX}; 1 = wall or visited.
- move_ready  in  1  downstream consumer accepts Move.
- ldX, ldY, IncX, IncY, DecX, DecY, pushSQ, popSQ, SQ_Read, selMove  out  1 each  datapath controls.
- SQ_Input  out  2  direction to push.
- dp_clr  out  1  one-cycle synchronous clear of the position registers and SQ; the top level merges it into the datapath reset.
- mem_we  out  1  write 1 to {poseY,poseX}.
- move_valid  out  1  equals selMove.
- busy, done, fail  out  1 each  status.

## Operation
- Direction encoding: 0 = right (X+1), 1 = down (Y+1), 2 = left (X-1), 3 = up (Y-1).
- Opposite direction = dir XOR 2.
- 2-bit try counter d.
- States: IDLE, CLEAR, MARK, TRY, BACK, REPLAY, DONE, FAIL.
- IDLE: if start, go to CLEAR.
- CLEAR: assert dp_clr; set d = 0; go to MARK.
- MARK: no inc/dec; assert mem_we (marks the current cell).
  - If poseX==GOAL_X and poseY==GOAL_Y, go to REPLAY.
  - Otherwise go to TRY.
- TRY: drive the inc/dec pair for direction d.
  - If !overflow and mem_rdata==0: assert ldX and ldY, assert pushSQ with SQ_Input=d, set d = 0, go to MARK.
  - Else, if d==3, go to BACK; otherwise d = d+1 and stay in TRY.
- BACK:
  - If SQ_Empty, go to FAIL.
  - Otherwise drive the opposite of topValueSQ, assert ldX, ldY and popSQ.
  - If topValueSQ==3, stay in BACK. Otherwise set d = topValueSQ+1 and go to TRY.
- REPLAY: assert selMove; SQ_Read = move_ready & !SQ_Done.
  - If SQ_Done, go to DONE.
- DONE and FAIL: hold done or fail. A new start goes to CLEAR.
- busy = 1 in every state except IDLE, DONE and FAIL.
- All control outputs are Moore/Mealy combinational from state, d and inputs. Every output not named for a state is 0.
- An inc and a dec on the same axis are never asserted together.
- start during busy is ignored.

## Timing
- Reset (rst==0) takes the FSM to IDLE at once and clears d. All outputs read 0 during reset and in IDLE.
- Reset mid-search or mid-replay aborts; no partial state survives.
- One datapath update per cycle: a load, push or pop takes effect at the same edge the FSM leaves the state.
- Forward step costs MARK + (k+1) TRY cycles, where k = number of rejected directions.
- Backtrack costs 1 BACK cycle per popped entry.
- Goal equal to (0,0): CLEAR, MARK, then REPLAY. SQ_Done is already 1, so DONE follows immediately with zero moves.
- Replay throughput is one move per cycle while move_ready=1. With move_ready=0, Move is held and the queue does not advance.

## Structure
- Package im_pkg holds:
  - dir_t (2-bit enum RIGHT, DOWN, LEFT, UP),
  - state_t enum,
  - a function opposite(dir_t).
- Sub-module im_dir_decode: combinational; dir_t plus enable in, IncX/IncY/DecX/DecY out. The FSM instantiates it once; its input mux selects d or opposite(topValueSQ).
- FSM and counter in one always_ff block with asynchronous reset on negedge rst.

## Test plan
- Empty maze, default goal. Count the edge that samples start in IDLE as edge 1. REPLAY is entered after edge 78. The replay streams 15 moves of 0 then 15 moves of 1, then done=1.
- Wall column at X=1 for all Y, goal (15,15). Search exhausts, BACK reaches SQ_Empty, fail=1, done=0, mem_we was asserted for cells (0,0)..(0,15) only.
- Dead end: walls force the path into the corridor (0,0)->(1,0)->(2,0), which is a dead end, with the open route via (0,1). BACK issues 2 pops with DecX, then TRY resumes with d=1 at (0,0). The final replayed path contains no 0 moves toward (2,0).
- Replay with move_ready toggling 1,0,0,1: SQ_Read asserts only in ready cycles; Move stays stable across the stalls.
- Pull rst low in the 10th TRY cycle: all outputs go to 0 within the same cycle. After release and a new start, CLEAR asserts dp_clr.
- GOAL_X=0, GOAL_Y=0: done=1 three cycles after start is sampled, with no move_valid&move_ready transfer.

Source files
------------

// File: rtl/im_pkg.sv
// Shared types for the intelligent-mouse maze controller: move directions,
// controller states and the direction-reversal helper used when backtracking.
package im_pkg;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        UP    = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_MARK   = 3'd2,
        S_TRY    = 3'd3,
        S_BACK   = 3'd4,
        S_REPLAY = 3'd5,
        S_DONE   = 3'd6,
        S_FAIL   = 3'd7
    } state_t;

    // Flipping bit 1 swaps right<->left and down<->up.
    function automatic dir_t opposite(input dir_t dir);
        return dir_t'(dir ^ 2'b10);
    endfunction

endpackage

// File: rtl/im_dir_decode.sv
// Turns one direction into the single inc/dec strobe for the X/Y position
// registers; nothing is driven while the enable is low.
module im_dir_decode
    import im_pkg::*;
(
    input  dir_t i_dir,
    input  logic i_en,
    output logic o_inc_x,
    output logic o_inc_y,
    output logic o_dec_x,
    output logic o_dec_y
);

    always_comb begin
        o_inc_x = 1'b0;
        o_inc_y = 1'b0;
        o_dec_x = 1'b0;
        o_dec_y = 1'b0;
        if (i_en) begin
            case (i_dir)
                RIGHT:   o_inc_x = 1'b1;
                DOWN:    o_inc_y = 1'b1;
                LEFT:    o_dec_x = 1'b1;
                UP:      o_dec_y = 1'b1;
                default: o_inc_x = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/im_controller.sv
// Depth-first maze search sequencer for the mouse datapath: marks visited
// cells, backtracks through the stack, then streams the recorded path out.
//   state  | meaning
//   IDLE   | waiting for start
//   CLEAR  | clear position registers and stack/queue
//   MARK   | mark current cell visited, test for goal
//   TRY    | probe direction d from current cell
//   BACK   | pop one step and move back along it
//   REPLAY | stream stored moves, one per accepted cycle
//   DONE   | path found and fully streamed
//   FAIL   | stack exhausted, no path
module im_controller
    import im_pkg::*;
#(
    parameter logic [3:0] GOAL_X = 4'd15,
    parameter logic [3:0] GOAL_Y = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] poseX,
    input  logic [3:0] poseY,
    input  logic       overflow,
    input  logic [1:0] topValueSQ,
    input  logic       SQ_Empty,
    input  logic       SQ_Done,
    input  logic       mem_rdata,
    input  logic       move_ready,
    output logic       ldX,
    output logic       ldY,
    output logic       IncX,
    output logic       IncY,
    output logic       DecX,
    output logic       DecY,
    output logic       pushSQ,
    output logic       popSQ,
    output logic       SQ_Read,
    output logic       selMove,
    output logic [1:0] SQ_Input,
    output logic       dp_clr,
    output logic       mem_we,
    output logic       move_valid,
    output logic       busy,
    output logic       done,
    output logic       fail
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_d;
    logic [1:0] w_d_nxt;
    dir_t       w_dir_sel;
    logic       w_dir_en;
    logic       w_inc_x;
    logic       w_inc_y;
    logic       w_dec_x;
    logic       w_dec_y;

    im_dir_decode u_dir_decode (
        .i_dir   (w_dir_sel),
        .i_en    (w_dir_en),
        .o_inc_x (w_inc_x),
        .o_inc_y (w_inc_y),
        .o_dec_x (w_dec_x),
        .o_dec_y (w_dec_y)
    );

    assign IncX       = w_inc_x;
    assign IncY       = w_inc_y;
    assign DecX       = w_dec_x;
    assign DecY       = w_dec_y;
    assign move_valid = selMove;
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_FAIL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_d     <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_dir_sel   = dir_t'(r_d);
        w_dir_en    = 1'b0;
        ldX         = 1'b0;
        ldY         = 1'b0;
        pushSQ      = 1'b0;
        popSQ       = 1'b0;
        SQ_Read     = 1'b0;
        selMove     = 1'b0;
        SQ_Input    = 2'd0;
        dp_clr      = 1'b0;
        mem_we      = 1'b0;
        done        = 1'b0;
        fail        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                dp_clr      = 1'b1;
                w_d_nxt     = 2'd0;
                w_state_nxt = S_MARK;
            end
            S_MARK: begin
                mem_we = 1'b1;
                if (poseX == GOAL_X && poseY == GOAL_Y) w_state_nxt = S_REPLAY;
                else                                    w_state_nxt = S_TRY;
            end
            S_TRY: begin
                w_dir_en = 1'b1;
                if (!overflow && !mem_rdata) begin
                    ldX         = 1'b1;
                    ldY         = 1'b1;
                    pushSQ      = 1'b1;
                    SQ_Input    = r_d;
                    w_d_nxt     = 2'd0;
                    w_state_nxt = S_MARK;
                end else if (r_d == 2'd3) begin
                    w_state_nxt = S_BACK;
                end else begin
                    w_d_nxt = r_d + 2'd1;
                end
            end
            S_BACK: begin
                if (SQ_Empty) begin
                    w_state_nxt = S_FAIL;
                end else begin
                    w_dir_sel = opposite(dir_t'(topValueSQ));
                    w_dir_en  = 1'b1;
                    ldX       = 1'b1;
                    ldY       = 1'b1;
                    popSQ     = 1'b1;
                    if (topValueSQ != 2'd3) begin
                        w_d_nxt     = topValueSQ + 2'd1;
                        w_state_nxt = S_TRY;
                    end
                end
            end
            S_REPLAY: begin
                // Move is only meaningful while the queue still holds entries.
                selMove = !SQ_Done;
                SQ_Read = move_ready & !SQ_Done;
                if (SQ_Done) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = S_CLEAR;
            end
            S_FAIL: begin
                fail = 1'b1;
                if (start) w_state_nxt = S_CLEAR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_im_controller.sv
// Bench for im_controller: two instances (default goal and goal at origin)
// each wired to a behavioural datapath, stack/queue and maze RAM model.
module tb_im_controller;
    import im_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic move_ready = 1'b1;
    logic [1:0] start = 2'b00;

    logic [1:0][3:0] pose_x, pose_y, r_x, r_y;
    logic [1:0]      ovf, mem_rdata, sq_empty, sq_done;
    logic [1:0][1:0] top_sq, move;
    logic [1:0][8:0] r_sp, r_rp;
    logic [1:0]      r_sq [2][256];
    logic            r_vis [2][256];
    logic            wall [2][256];

    wire [1:0]       ld_x, ld_y, inc_x, inc_y, dec_x, dec_y, push_sq, pop_sq;
    wire [1:0]       sq_read, sel_move, dp_clr, mem_we, move_valid, busy, done, fail;
    wire [1:0][1:0]  sq_in;
    wire [1:0]       any_out;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops, n_pop_decx;
    bit res_seen;
    logic res_inc_y, res_origin, clr_edge1;
    logic [1:0] moves [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam logic [3:0] GOAL = (g == 0) ? 4'd15 : 4'd0;
        im_controller #(.GOAL_X(GOAL), .GOAL_Y(GOAL)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .poseX      (pose_x[g]),
            .poseY      (pose_y[g]),
            .overflow   (ovf[g]),
            .topValueSQ (top_sq[g]),
            .SQ_Empty   (sq_empty[g]),
            .SQ_Done    (sq_done[g]),
            .mem_rdata  (mem_rdata[g]),
            .move_ready (move_ready),
            .ldX        (ld_x[g]),
            .ldY        (ld_y[g]),
            .IncX       (inc_x[g]),
            .IncY       (inc_y[g]),
            .DecX       (dec_x[g]),
            .DecY       (dec_y[g]),
            .pushSQ     (push_sq[g]),
            .popSQ      (pop_sq[g]),
            .SQ_Read    (sq_read[g]),
            .selMove    (sel_move[g]),
            .SQ_Input   (sq_in[g]),
            .dp_clr     (dp_clr[g]),
            .mem_we     (mem_we[g]),
            .move_valid (move_valid[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .fail       (fail[g])
        );
        assign any_out[g] = ld_x[g] | ld_y[g] | inc_x[g] | inc_y[g] | dec_x[g] | dec_y[g]
                          | push_sq[g] | pop_sq[g] | sq_read[g] | sel_move[g] | (|sq_in[g])
                          | dp_clr[g] | mem_we[g] | move_valid[g] | busy[g] | done[g] | fail[g];
    end

    // Datapath, stack/queue and maze RAM model.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            pose_x[g]    = r_x[g] + {3'b000, inc_x[g]} - {3'b000, dec_x[g]};
            pose_y[g]    = r_y[g] + {3'b000, inc_y[g]} - {3'b000, dec_y[g]};
            ovf[g]       = (inc_x[g] & (r_x[g] == 4'hF)) | (dec_x[g] & (r_x[g] == 4'h0))
                         | (inc_y[g] & (r_y[g] == 4'hF)) | (dec_y[g] & (r_y[g] == 4'h0));
            mem_rdata[g] = wall[g][{pose_y[g], pose_x[g]}] | r_vis[g][{pose_y[g], pose_x[g]}];
            sq_empty[g]  = (r_sp[g] == 9'd0);
            sq_done[g]   = (r_rp[g] == r_sp[g]);
            top_sq[g]    = sq_empty[g] ? 2'd0 : r_sq[g][8'(r_sp[g] - 9'd1)];
            move[g]      = r_sq[g][r_rp[g][7:0]];
        end
    end

    always_ff @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (dp_clr[g]) begin
                r_x[g]  <= 4'd0;
                r_y[g]  <= 4'd0;
                r_sp[g] <= 9'd0;
                r_rp[g] <= 9'd0;
                for (int c = 0; c < 256; c++) r_vis[g][c] <= 1'b0;
            end else begin
                if (ld_x[g]) r_x[g] <= pose_x[g];
                if (ld_y[g]) r_y[g] <= pose_y[g];
                if (mem_we[g]) r_vis[g][{pose_y[g], pose_x[g]}] <= 1'b1;
                if (push_sq[g]) begin
                    r_sq[g][r_sp[g][7:0]] <= sq_in[g];
                    r_sp[g] <= r_sp[g] + 9'd1;
                end else if (pop_sq[g]) begin
                    r_sp[g] <= r_sp[g] - 9'd1;
                end
                if (sq_read[g]) r_rp[g] <= r_rp[g] + 9'd1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // kind 0 = open maze, 1 = wall column at X=1, 2 = dead-end corridor on row 0
    task automatic set_walls(input int kind);
        for (int c = 0; c < 256; c++) begin
            wall[0][c] = 1'b0;
            wall[1][c] = 1'b0;
        end
        if (kind == 1) begin
            for (int y = 0; y < 16; y++) wall[0][y * 16 + 1] = 1'b1;
        end else if (kind == 2) begin
            wall[0][8'h03] = 1'b1;
            wall[0][8'h11] = 1'b1;
            wall[0][8'h12] = 1'b1;
        end
    endtask

    task automatic run_search(input bit hold, output int edges);
        bit last_pop;
        n_pops = 0; n_pop_decx = 0; res_seen = 0;
        res_inc_y = 1'b0; res_origin = 1'b0; clr_edge1 = 1'b0;
        last_pop = 0;
        edges = 0;
        @(negedge clk);
        start[0] = 1'b1;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) clr_edge1 = dp_clr[0];
            if (!hold) start[0] = 1'b0;
            if (last_pop && !pop_sq[0] && !res_seen && n_pops == 2) begin
                res_seen   = 1;
                res_inc_y  = inc_y[0];
                res_origin = (r_x[0] == 4'd0) && (r_y[0] == 4'd0);
            end
            last_pop = pop_sq[0];
            if (pop_sq[0]) begin
                n_pops++;
                if (dec_x[0]) n_pop_decx++;
            end
        end while (!sel_move[0] && !fail[0] && edges < 5000);
        start[0] = 1'b0;
        check_val("search_in_budget", edges < 5000, 1);
    endtask

    task automatic run_replay(input bit toggle);
        logic [3:0] rdy_pat;
        logic       prev_rdy;
        logic [1:0] prev_mv;
        bit         have_prev;
        int         cyc;
        rdy_pat = 4'b1001;
        moves.delete();
        have_prev = 0; prev_rdy = 1'b1; prev_mv = 2'd0;
        cyc = 0;
        while (!done[0] && !fail[0] && cyc < 500) begin
            move_ready = toggle ? rdy_pat[cyc[1:0]] : 1'b1;
            #1;
            if (sel_move[0]) begin
                if (toggle) begin
                    check_val("move_valid", move_valid[0], 1);
                    check_val("sq_read_gate", sq_read[0], move_ready & ~sq_done[0]);
                    if (have_prev && !prev_rdy) check_val("move_hold", move[0], prev_mv);
                end
                if (move_ready && !sq_done[0]) moves.push_back(move[0]);
                have_prev = 1; prev_rdy = move_ready; prev_mv = move[0];
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        move_ready = 1'b1;
        check_val("replay_in_budget", cyc < 500, 1);
    endtask

    task automatic check_path(input int kind);
        logic [1:0] exp_q [$];
        if (kind == 0) begin
            repeat (15) exp_q.push_back(2'd0);
            repeat (15) exp_q.push_back(2'd1);
        end else begin
            repeat (2)  exp_q.push_back(2'd1);
            repeat (15) exp_q.push_back(2'd0);
            repeat (13) exp_q.push_back(2'd1);
        end
        check_val("path_len", moves.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < moves.size(); i++)
            check_val($sformatf("path_mv%0d", i), moves[i], exp_q[i]);
        check_val("end_done", done[0], 1);
        check_val("end_busy", busy[0], 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, tries, cyc, col0, other, xfer;
        set_walls(0);
        start = 2'b01;
        #22;
        check_val("rst_out0", any_out[0], 0);
        check_val("rst_out1", any_out[1], 0);
        start = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("idle_out0", any_out[0], 0);

        // open maze, default goal
        run_search(0, edges);
        check_val("open_replay_edge", edges, 78);
        check_val("open_clr_edge1", clr_edge1, 1);
        check_val("open_no_pops", n_pops, 0);
        run_replay(0);
        check_path(0);

        // start held through the search, stalled replay
        run_search(1, edges);
        check_val("hold_replay_edge", edges, 78);
        run_replay(1);
        check_path(0);

        // reset in the 10th TRY cycle
        @(negedge clk);
        start[0] = 1'b1;
        tries = 0; cyc = 0;
        while (tries < 10 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            start[0] = 1'b0;
            if (busy[0] && (inc_x[0] | inc_y[0] | dec_x[0] | dec_y[0]) && !pop_sq[0]) tries++;
        end
        check_val("rst_try_count", tries, 10);
        rst = 1'b0;
        #1;
        check_val("rst_mid_out", any_out[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_search(0, edges);
        check_val("rst_clr_edge1", clr_edge1, 1);
        check_val("rst_replay_edge", edges, 78);
        run_replay(0);
        check_path(0);

        // wall column at X=1: unreachable goal
        set_walls(1);
        run_search(0, edges);
        check_val("wall_fail", fail[0], 1);
        check_val("wall_done", done[0], 0);
        check_val("wall_busy", busy[0], 0);
        check_val("wall_pops", n_pops, 15);
        col0 = 0; other = 0;
        for (int c = 0; c < 256; c++) begin
            if (r_vis[0][c]) begin
                if (c[3:0] == 4'd0) col0++;
                else                other++;
            end
        end
        check_val("wall_marked_col0", col0, 16);
        check_val("wall_marked_other", other, 0);

        // dead-end corridor (0,0)->(2,0)
        set_walls(2);
        run_search(0, edges);
        check_val("dead_pops", n_pops, 2);
        check_val("dead_pop_decx", n_pop_decx, 2);
        check_val("dead_resume_seen", res_seen, 1);
        check_val("dead_resume_incy", res_inc_y, 1);
        check_val("dead_resume_origin", res_origin, 1);
        run_replay(0);
        check_path(2);

        // goal at origin on the second instance
        set_walls(0);
        move_ready = 1'b1;
        @(negedge clk);
        start[1] = 1'b1;
        xfer = 0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                start[1] = 1'b0;
                check_val("zero_clr", dp_clr[1], 1);
            end
            if (e == 2) check_val("zero_mark_we", mem_we[1], 1);
            if (e == 3) check_val("zero_done_early", done[1], 0);
            if (move_valid[1] & move_ready) xfer++;
        end
        check_val("zero_done", done[1], 1);
        check_val("zero_xfer", xfer, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
